// File: rtl/uart_fifo_pkg.sv
// Shared sizing, types and pointer helper for the 128x8 UART FIFO.
package uart_fifo_pkg;

    localparam int FIFO_DEPTH = 128;
    localparam int FIFO_BITS  = 7;
    localparam int FIFO_WIDTH = 8;

    typedef logic [FIFO_BITS-1:0]  ptr_t;
    typedef logic [FIFO_WIDTH-1:0] data_t;

    // One slot stays unused so a 7-bit counter can tell full from empty.
    localparam ptr_t COUNT_FULL  = ptr_t'(FIFO_DEPTH - 1);
    localparam ptr_t COUNT_EMPTY = '0;

    // Controller state kept as a single register bundle.
    typedef struct packed {
        ptr_t  rd_ptr;
        ptr_t  wr_ptr;
        ptr_t  count;
        logic  read_n_hold;
        data_t data_out;
    } ctrl_state_t;

    localparam ctrl_state_t CTRL_RESET = '{
        rd_ptr:      '0,
        wr_ptr:      '0,
        count:       '0,
        read_n_hold: 1'b1,
        data_out:    '0
    };

    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/uart_fifo_128x8_if.sv
// Data/strobe/flag bundle between a FIFO user (master) and the FIFO (slave).
interface uart_fifo_128x8_if;
    import uart_fifo_pkg::*;

    data_t data_in;
    logic  write_n;
    logic  read_n;
    ptr_t  level;
    data_t data_out;
    logic  full;
    logic  empty;
    logic  half;

    modport master (
        output data_in, write_n, read_n, level,
        input  data_out, full, empty, half
    );

    modport slave (
        input  data_in, write_n, read_n, level,
        output data_out, full, empty, half
    );

endinterface

// File: rtl/uart_fifo_ram_128x8.sv
// Simple dual-port 128x8 RAM: synchronous write, registered read address, combinational read data.
module uart_fifo_ram_128x8
    import uart_fifo_pkg::*;
(
    input  logic  clock,
    input  logic  reset_n,
    input  logic  we_i,
    input  ptr_t  waddr_i,
    input  data_t wdata_i,
    input  ptr_t  raddr_i,
    output data_t rdata_o
);

    data_t mem [FIFO_DEPTH];
    ptr_t  raddr_q;

    // NOTE: the array is deliberately left without reset so it maps onto a block RAM;
    // a reset term on storage would force it into flip-flops.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            raddr_q <= '0;
        end else begin
            raddr_q <= raddr_i;
        end
    end

    assign rdata_o = mem[raddr_q];

endmodule

// File: rtl/uart_fifo_128x8.sv
// 128x8 FIFO controller: pointers, occupancy counter, flags and registered read data.
// Define FIFO_OVERFLOW_CHECK_EN to compile in simulation-only overflow/underflow traps.
module uart_fifo_128x8
    import uart_fifo_pkg::*;
(
    input logic               clock,
    input logic               reset_n,
    uart_fifo_128x8_if.slave  bus
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    data_t       ram_rdata;
    logic        full;
    logic        empty;
    logic        wr_accept;
    logic        rd_accept;

    assign full  = (state_q.count == COUNT_FULL);
    assign empty = (state_q.count == COUNT_EMPTY);

    assign wr_accept = !bus.write_n && !full;
    assign rd_accept = !bus.read_n && !empty;

    // NOTE: every field of state_d takes its held value first, so no path through
    // this block leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        state_d = state_q;

        if (wr_accept) begin
            state_d.wr_ptr = ptr_inc(state_q.wr_ptr);
        end
        if (rd_accept) begin
            state_d.rd_ptr = ptr_inc(state_q.rd_ptr);
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   state_d.count = state_q.count + ptr_t'(1);
            2'b01:   state_d.count = state_q.count - ptr_t'(1);
            default: state_d.count = state_q.count;
        endcase

        // The RAM address was captured alongside this strobe, so its data is ready now.
        state_d.read_n_hold = bus.read_n;
        if (!state_q.read_n_hold) begin
            state_d.data_out = ram_rdata;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CTRL_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    uart_fifo_ram_128x8 u_ram (
        .clock   (clock),
        .reset_n (reset_n),
        .we_i    (wr_accept),
        .waddr_i (state_q.wr_ptr),
        .wdata_i (bus.data_in),
        .raddr_i (state_q.rd_ptr),
        .rdata_o (ram_rdata)
    );

    assign bus.data_out = state_q.data_out;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.half     = (state_q.count >= bus.level);

`ifdef FIFO_OVERFLOW_CHECK_EN
    always @(posedge clock) begin
        if (reset_n) begin
            if (!bus.write_n && full) begin
                $display("FIFO Overflow at time %0t", $time);
                $stop;
            end
            if (!bus.read_n && empty) begin
                $display("FIFO Underflow at time %0t", $time);
                $stop;
            end
        end
    end
`else
    // Without the traps, writes when full and reads when empty are dropped silently.
`endif

endmodule

// File: tb/tb_uart_fifo_128x8.sv
// Scoreboard bench for uart_fifo_128x8: driver pushes expected read data, a monitor pops and compares.
module tb_uart_fifo_128x8;
    import uart_fifo_pkg::*;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    uart_fifo_128x8_if bus ();

    uart_fifo_128x8 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_mem [128];
    int         m_wp;
    int         m_rp;
    int         m_cnt;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wp  = 0;
        m_rp  = 0;
        m_cnt = 0;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_empty"}, 32'(bus.empty), 32'(m_cnt == 0));
        check({tag, "_full"},  32'(bus.full),  32'(m_cnt == 127));
        check({tag, "_half"},  32'(bus.half),  32'(m_cnt >= int'(bus.level)));
    endtask

    // One clock of stimulus; expected read data is queued before the edge.
    task automatic cycle(input bit wr, input bit rd, input logic [7:0] din);
        bit         wacc;
        bit         racc;
        logic [7:0] exp_data;
        @(negedge clock);
        bus.write_n = !wr;
        bus.read_n  = !rd;
        bus.data_in = din;
        wacc = wr && (m_cnt != 127);
        racc = rd && (m_cnt != 0);
        if (rd) begin
            if (racc)      exp_data = m_mem[m_rp];
            else if (wacc) exp_data = din;
            else           exp_data = m_mem[m_rp];
            exp_q.push_back(exp_data);
        end
        @(posedge clock);
        #1;
        if (wacc) begin
            m_mem[m_wp] = din;
            m_wp = (m_wp + 1) % 128;
        end
        if (racc) m_rp = (m_rp + 1) % 128;
        m_cnt = m_cnt + int'(wacc) - int'(racc);
        check_flags("cyc");
    endtask

    task automatic probe_count(input int lvl, input bit exp_half, input string name);
        bus.level = ptr_t'(lvl);
        #1;
        check(name, 32'(bus.half), 32'(exp_half));
    endtask

    // Monitor: data_out is due one edge after the edge that sampled read_n low.
    initial begin
        bit         strobe_prev;
        bit         strobe_now;
        logic [7:0] e;
        strobe_prev = 1'b0;
        forever begin
            @(posedge clock);
            strobe_now = reset_n && !bus.read_n;
            #1;
            if (!reset_n) begin
                strobe_prev = 1'b0;
                exp_q.delete();
            end else begin
                if (strobe_prev) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_underrun: data_out 0x%0h with no expected entry", bus.data_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("data_out", 32'(bus.data_out), 32'(e));
                    end
                end
                strobe_prev = strobe_now;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.data_in = 8'h00;
        bus.write_n = 1'b1;
        bus.read_n  = 1'b1;
        bus.level   = 7'd64;
        reset_n     = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_empty",    32'(bus.empty),    32'd1);
        check("rst_full",     32'(bus.full),     32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'h00);
        check("rst_half64",   32'(bus.half),     32'd0);
        bus.level = 7'd0;
        #1;
        check("rst_half0", 32'(bus.half), 32'd1);
        bus.level = 7'd64;
        @(negedge clock);
        reset_n = 1'b1;

        // Three writes then three back-to-back reads
        cycle(1, 0, 8'h11);
        cycle(1, 0, 8'h22);
        cycle(1, 0, 8'h33);
        repeat (3) cycle(0, 1, 8'h00);
        repeat (2) cycle(0, 0, 8'h00);
        check("t2_empty", 32'(bus.empty), 32'd1);

        // Fill to capacity, overflow attempt, read+write while full, drain
        for (int i = 0; i < 127; i++) cycle(1, 0, 8'(i));
        check("t3_full", 32'(bus.full), 32'd1);
        cycle(1, 0, 8'hFF);
        check("t3_full_hold", 32'(bus.full), 32'd1);
        cycle(1, 1, 8'hEE);
        check("t3_rw_full", 32'(bus.full), 32'd0);
        probe_count(126, 1'b1, "t3_cnt_ge126");
        probe_count(127, 1'b0, "t3_cnt_lt127");
        bus.level = 7'd64;
        for (int i = 0; i < 126; i++) cycle(0, 1, 8'h00);
        repeat (2) cycle(0, 0, 8'h00);
        check("t3_empty", 32'(bus.empty), 32'd1);

        // Half threshold at level 64
        for (int i = 0; i < 63; i++) cycle(1, 0, 8'(8'h40 + i));
        check("t4_half_63", 32'(bus.half), 32'd0);
        cycle(1, 0, 8'h99);
        check("t4_half_64", 32'(bus.half), 32'd1);
        cycle(0, 1, 8'h00);
        check("t4_half_read", 32'(bus.half), 32'd0);
        for (int i = 0; i < 63; i++) cycle(0, 1, 8'h00);
        repeat (2) cycle(0, 0, 8'h00);

        // Simultaneous read+write at count 5 and at count 0
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'hA0 + i));
        cycle(1, 1, 8'hA5);
        probe_count(5, 1'b1, "t5_cnt_ge5");
        probe_count(6, 1'b0, "t5_cnt_lt6");
        bus.level = 7'd64;
        repeat (5) cycle(0, 1, 8'h00);
        repeat (2) cycle(0, 0, 8'h00);
        cycle(1, 1, 8'h5A);
        check("t5_rw_empty", 32'(bus.empty), 32'd0);
        probe_count(1, 1'b1, "t5_cnt_ge1");
        probe_count(2, 1'b0, "t5_cnt_lt2");
        bus.level = 7'd64;
        cycle(0, 1, 8'h00);
        repeat (2) cycle(0, 0, 8'h00);

        // Streaming across the pointer wrap with occupancy 2..3
        cycle(1, 0, 8'hC0);
        cycle(1, 0, 8'hC1);
        for (int i = 0; i < 200; i++) begin
            cycle(1, 0, 8'(8'hC2 + i));
            cycle(0, 1, 8'h00);
        end

        // Asynchronous reset mid-stream
        #2;
        bus.write_n = 1'b1;
        bus.read_n  = 1'b1;
        reset_n     = 1'b0;
        #1;
        check("mid_rst_empty",    32'(bus.empty),    32'd1);
        check("mid_rst_full",     32'(bus.full),     32'd0);
        check("mid_rst_data_out", 32'(bus.data_out), 32'h00);
        model_reset();
        @(posedge clock);
        #1;
        check("mid_rst_hold", 32'(bus.data_out), 32'h00);
        @(negedge clock);
        reset_n = 1'b1;
        cycle(0, 0, 8'h00);
        cycle(1, 0, 8'h3C);
        cycle(0, 1, 8'h00);
        repeat (3) cycle(0, 0, 8'h00);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_fifo_128x8.md
Name: uart_fifo_128x8

Overview:
- Single-clock synchronous 128-entry x 8-bit FIFO for the UART transmit and receive data paths.
- The storage is a dual-port RAM. The write port is synchronous. The read port has a registered read address.
- The controller provides a read and write pointer pair, an occupancy counter, full/empty/threshold flags, and a registered output data stage.

Parameters:
- FIFO_DEPTH, 128, number of RAM locations; usable capacity is FIFO_DEPTH-1 = 127.
- FIFO_BITS, 7, pointer and counter width (log2 FIFO_DEPTH).
- FIFO_WIDTH, 8, data width.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  8  write data.
- write_n  input  1  write strobe, active low, one entry per cycle.
- read_n  input  1  read strobe, active low, one entry per cycle.
- level  input  7  threshold for the half flag.
- data_out  output  8  registered read data.
- full  output  1  high when counter == 127.
- empty  output  1  high when counter == 0.
- half  output  1  high when counter >= level (unsigned compare).

Behaviour:
- Reset (reset_n low, asynchronous): the following registers clear.
  - rd_pointer, wr_pointer and counter go to 0.
  - The RAM read-address register goes to 0.
  - read_n_hold goes to 1.
  - data_out goes to 0x00.
  - RAM contents are not cleared.
- Flags are combinational from counter.
  - After reset: empty=1, full=0, half=(level==0).
- Accepted write: write_n==0 and full==0.
  - mem[wr_pointer] <= data_in.
  - wr_pointer increments modulo 128 (127 -> 0).
- Accepted read: read_n==0 and empty==0.
  - rd_pointer increments modulo 128.
- Counter update:
  - Accepted write only: counter +1.
  - Accepted read only: counter -1.
  - Both accepted, or neither: counter unchanged.
- Write while full is ignored: no memory write, no pointer or counter change.
- Read while empty is ignored: no pointer or counter change.
- Simultaneous read+write while empty: the write is accepted, the read is ignored, and counter goes to 1.
- Simultaneous read+write while full: the read is accepted, the write is ignored, and counter goes to 126.
- Read pipeline (read strobe sampled low at edge N):
  - At edge N, the RAM address register captures the pre-increment rd_pointer, and read_n_hold <= read_n.
  - At edge N+1, if read_n_hold==0, data_out <= RAM output, i.e. mem[old rd_pointer].
  - Otherwise data_out holds its value.
  - data_out is therefore valid after edge N+1. Back-to-back reads stream one byte per cycle.
- data_out update is qualified only by the delayed strobe, not by acceptance. A read attempted while empty re-presents the last addressed entry.
- Read and write addresses can never collide on the same cycle with valid data, so there is no read-during-write hazard.
- Reset mid-operation discards all contents immediately; the FIFO is empty on release.

Optional Feature:
- Macro FIFO_OVERFLOW_CHECK_EN.
- Defined: simulation-only checks are compiled in.
  - A write attempted while full prints "FIFO Overflow" with $time and calls $stop.
  - A read attempted while empty prints "FIFO Underflow" and calls $stop.
- Undefined: no checks are compiled in. Ignored accesses are silent. Synthesised logic is identical either way.

Decomposition:
- Package uart_fifo_pkg holds FIFO_DEPTH, FIFO_BITS, FIFO_WIDTH and the pointer typedef logic [FIFO_BITS-1:0].
- Sub-module uart_fifo_ram_128x8:
  - Simple dual-port RAM: write port (clock, we, waddr, wdata).
  - Read port has an address register clocked by clock and async-cleared by reset_n, followed by a combinational data output.
  - Maps to one RAM64x18 in 128x8 mode on SmartFusion2.
- The controller holds the pointers, counter, flags, read_n_hold and the data_out register.

Test Plan:
- Reset → empty=1, full=0, data_out=0x00; with level=64, half=0.
- Write 0x11, 0x22, 0x33 on consecutive cycles, then read 3 back-to-back → data_out=0x11, 0x22, 0x33 on the cycles after edges N+1, N+2, N+3; empty=1 at the end.
- Write 127 bytes 0x00..0x7E → full=1 after the 127th write; an extra write of 0xFF is ignored (counter stays 127); reading 127 returns 0x00..0x7E in order.
- level=64: write 63 → half=0; the 64th write → half=1; one read → half=0.
- Simultaneous read+write with counter=5 → counter stays 5; with counter=0 → counter=1, empty=0.
- Pointer wrap: 200 write/read pairs interleaved with occupancy of 2–3 → data integrity across the 127→0 pointer wrap; an async reset asserted mid-stream → empty=1 immediately and data_out=0x00.
